// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 word mux among four requesters,
// with a hold counter that bounds each tenure while others wait.
module mux4_rr_arbiter #(
    parameter int IW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    input  logic [3:0]    i_Req,
    input  logic [IW-1:0] i_Data1,
    input  logic [IW-1:0] i_Data2,
    input  logic [IW-1:0] i_Data3,
    input  logic [IW-1:0] i_Data4,
    output logic [3:0]    o_Grant,
    output logic [1:0]    o_Select,
    output logic [IW-1:0] o_Data,
    output logic          o_Valid
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_owner, r_last, w_owner_nxt, w_last_nxt, w_base, w_pick, w_idx;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]    r_grant, w_grant_nxt, w_others;
    logic [IW-1:0] r_data, w_data_nxt, w_mux;
    logic          r_valid, w_valid_nxt, w_beat;

    assign w_mux = r_owner == 2'd0 ? i_Data1 :
                   r_owner == 2'd1 ? i_Data2 :
                   r_owner == 2'd2 ? i_Data3 : i_Data4;
    assign w_others  = i_Req & ~(4'b0001 << r_owner);
    assign w_beat    = (r_state == OWN) && i_Req[r_owner];
    assign w_cnt_inc = r_cnt == HOLD ? r_cnt : r_cnt + 1'b1;
    // Any hand-off from OWN first makes the owner the new last winner.
    assign w_base    = r_state == OWN ? r_owner : r_last;

    always_comb begin
        w_pick = w_base;
        w_idx  = w_base;
        for (int k = 4; k >= 1; k--) begin
            w_idx = w_base + 2'(k);
            if (i_Req[w_idx]) w_pick = w_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (|i_Req) begin
                w_state_nxt = OWN;
                w_owner_nxt = w_pick;
                w_grant_nxt = 4'b0001 << w_pick;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (w_beat) begin
                w_data_nxt  = w_mux;
                w_valid_nxt = 1'b1;
                w_cnt_nxt   = w_cnt_inc;
            end
            if (!w_beat || (w_cnt_inc == HOLD && |w_others)) begin
                w_last_nxt = r_owner;
                if (|w_others) begin
                    w_owner_nxt = w_pick;
                    w_grant_nxt = 4'b0001 << w_pick;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 4'b0000;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_grant <= 4'b0000;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign o_Grant  = r_grant;
    assign o_Select = r_owner;
    assign o_Data   = r_data;
    assign o_Valid  = r_valid;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed stimulus with a tenure-level reference model checked every cycle.
module tb_mux4_rr_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
    logic [3:0] o_grant;
    logic [1:0] o_select;
    logic [7:0] o_data;
    logic       o_valid;

    int n_checks = 0;
    int n_fail = 0;

    mux4_rr_arbiter #(.IW(8), .MAX_HOLD(MAX_HOLD)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req),
        .i_Data1(words[0]), .i_Data2(words[1]), .i_Data3(words[2]), .i_Data4(words[3]),
        .o_Grant(o_grant), .o_Select(o_select), .o_Data(o_data), .o_Valid(o_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: owner is -1 when idle, beats counts the whole tenure.
    int         m_own = -1, m_last = 3, m_beats = 0;
    logic [3:0] e_grant = 0;
    int         e_sel = 0, e_data = 0;
    bit         e_valid = 0, m_en = 0;

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int i = 1; i <= 4; i++)
            if (r[(last + i) % 4]) return (last + i) % 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        m_en = 1;
        if (!rst_n) begin
            m_own = -1; m_last = 3; m_beats = 0;
            e_grant = 0; e_sel = 0; e_data = 0; e_valid = 0;
        end else if (m_own < 0) begin
            e_valid = 0;
            if (req != 0) begin
                m_own = rr_pick(m_last, req);
                m_beats = 0;
                e_grant = 4'(1 << m_own);
                e_sel = m_own;
            end
        end else begin
            logic       beat;
            logic [3:0] others;
            beat = req[m_own];
            others = req & ~4'(1 << m_own);
            e_valid = beat;
            if (beat) begin
                e_data = words[m_own];
                m_beats++;
            end
            if (!beat || (m_beats >= MAX_HOLD && others != 0)) begin
                m_last = m_own;
                if (others != 0) begin
                    m_own = rr_pick(m_last, others);
                    m_beats = 0;
                    e_grant = 4'(1 << m_own);
                    e_sel = m_own;
                end else begin
                    m_own = -1;
                    e_grant = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("grant", o_grant, e_grant);
            chk("select", o_select, e_sel);
            chk("valid", o_valid, e_valid);
            chk("data", o_data, e_data);
        end
    end

    task automatic tick(input logic [3:0] r, input logic rn, input int n);
        req = r;
        rst_n = rn;
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    logic [3:0] pats [16] = '{4'b1111, 4'b0110, 4'b0000, 4'b1100, 4'b1100, 4'b1010, 4'b0001, 4'b0011,
                              4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b1000, 4'b0000, 4'b0101};

    initial begin
        tick(4'b1111, 1'b0, 2);
        chk("rst_grant", o_grant, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_select", o_select, 0);
        tick(4'b1111, 1'b1, 1);
        chk("first_grant", o_grant, 4'b0001);
        chk("first_select", o_select, 0);
        tick(4'b1111, 1'b1, 4);
        chk("rot_grant1", o_grant, 4'b0010);
        chk("rot_data1", o_data, 8'h11);
        tick(4'b1111, 1'b1, 12);
        chk("rot_wrap_grant", o_grant, 4'b0001);
        chk("rot_wrap_data", o_data, 8'h44);
        chk("rot_wrap_valid", o_valid, 1);

        tick(4'b0100, 1'b0, 1);
        tick(4'b0100, 1'b1, 1);
        chk("single_grant", o_grant, 4'b0100);
        chk("single_valid0", o_valid, 0);
        tick(4'b0100, 1'b1, 10);
        chk("single_hold", o_grant, 4'b0100);
        chk("single_data", o_data, 8'hA5);

        tick(4'b1010, 1'b0, 1);
        tick(4'b1010, 1'b1, 1);
        chk("early_grant1", o_grant, 4'b0010);
        tick(4'b1010, 1'b1, 2);
        tick(4'b1000, 1'b1, 1);
        chk("early_grant3", o_grant, 4'b1000);
        chk("early_gap", o_valid, 0);
        tick(4'b1000, 1'b1, 1);
        chk("early_resume", o_valid, 1);
        chk("early_data", o_data, 8'h44);

        tick(4'b1001, 1'b0, 1);
        tick(4'b1001, 1'b1, 1);
        chk("wrap_grant0", o_grant, 4'b0001);
        tick(4'b1001, 1'b1, 1);
        tick(4'b1000, 1'b1, 1);
        chk("wrap_grant3", o_grant, 4'b1000);

        tick(4'b0100, 1'b0, 1);
        tick(4'b0100, 1'b1, 2);
        chk("mid_beat1", o_valid, 1);
        tick(4'b0100, 1'b0, 1);
        chk("mid_rst_grant", o_grant, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_select", o_select, 0);
        tick(4'b0101, 1'b1, 1);
        chk("mid_after_grant", o_grant, 4'b0001);

        foreach (pats[i]) tick(pats[i], 1'b1, 1);
        tick(4'b0000, 1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
